ab_stream_feeder: RTL and testbench

// - Producer end of the a/b operand handshake: streams activation rows (a) and kernel rows (b) into the conv controller/datapath.
// - Walks the same loop nest: x, y, ch_in, ch_out, k_v (outer->inner); k_h is collapsed into one KERNEL_SIZE-lane word.
// - Reads activations and weights from two synchronous memories, inserts vertical zero-padding and absorbs downstream backpressure.

---
 rtl/cnn_pkg.sv | 42 ++++
 rtl/skid_fifo2.sv | 57 +++++
 rtl/ab_stream_feeder.sv | 164 ++++++++++++++++
 tb/tb_ab_stream_feeder.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/cnn_pkg.sv
// Shared types and helpers for the conv operand feeder.
package cnn_pkg;

  localparam int unsigned CNT_W = 32;

  // Default layer geometry.
  localparam int unsigned DEF_DATA_WIDTH  = 16;
  localparam int unsigned DEF_KERNEL_SIZE = 3;
  localparam int unsigned DEF_FM_WIDTH    = 1024;
  localparam int unsigned DEF_FM_HEIGHT   = 1024;
  localparam int unsigned DEF_CIN         = 64;
  localparam int unsigned DEF_COUT        = 64;
  localparam int unsigned DEF_ADDR_WIDTH  = 20;

  // Loop nest position, outer (x) to inner (k_v).
  typedef struct packed {
    logic [CNT_W-1:0] x;
    logic [CNT_W-1:0] y;
    logic [CNT_W-1:0] ch_in;
    logic [CNT_W-1:0] ch_out;
    logic [CNT_W-1:0] k_v;
  } loop_idx_t;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_STREAM = 2'd1,
    ST_DRAIN  = 2'd2
  } feeder_state_t;

  // Next value of a loop counter that wraps to 0 at its limit.
  function automatic logic [CNT_W-1:0] wrap_inc(input logic [CNT_W-1:0] v,
                                                input logic [CNT_W-1:0] lim);
    return (v >= lim - 32'd1) ? '0 : v + 32'd1;
  endfunction

  // True when the counter sits on its last value.
  function automatic logic is_last(input logic [CNT_W-1:0] v,
                                   input logic [CNT_W-1:0] lim);
    return (v >= lim - 32'd1);
  endfunction

endpackage

// File: rtl/skid_fifo2.sv
// Two-entry valid/ready FIFO; head entry drives the output.
module skid_fifo2 #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             arst_n_in,
  input  logic             push_valid,
  input  logic [WIDTH-1:0] push_data,
  output logic             pop_valid,
  output logic [WIDTH-1:0] pop_data,
  input  logic             pop_ready,
  output logic [1:0]       count
);

  logic [1:0][WIDTH-1:0] slot;
  logic                  push;
  logic                  pop;

  // A push while full is only taken if the head leaves in the same cycle.
  always_comb begin
    pop  = pop_ready && (count != 2'd0);
    push = push_valid && ((count != 2'd2) || pop);
  end

  assign pop_valid = (count != 2'd0);
  assign pop_data  = slot[0];

  // Storage and occupancy; slot[0] is always the head.
  always_ff @(posedge clk or negedge arst_n_in) begin
    if (!arst_n_in) begin
      slot  <= '0;
      count <= 2'd0;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (count == 2'd0) slot[0] <= push_data;
          else               slot[1] <= push_data;
          count <= count + 2'd1;
        end
        2'b01: begin
          slot[0] <= slot[1];
          count   <= count - 2'd1;
        end
        2'b11: begin
          if (count == 2'd1) begin
            slot[0] <= push_data;
          end else begin
            slot[0] <= slot[1];
            slot[1] <= push_data;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/ab_stream_feeder.sv
// Streams activation/kernel row pairs for one conv layer pass, with vertical
// zero padding and a 2-deep buffer to absorb downstream backpressure.
module ab_stream_feeder
  import cnn_pkg::*;
#(
  parameter int unsigned DATA_WIDTH         = DEF_DATA_WIDTH,
  parameter int unsigned KERNEL_SIZE        = DEF_KERNEL_SIZE,
  parameter int unsigned FEATURE_MAP_WIDTH  = DEF_FM_WIDTH,
  parameter int unsigned FEATURE_MAP_HEIGHT = DEF_FM_HEIGHT,
  parameter int unsigned INPUT_NB_CHANNELS  = DEF_CIN,
  parameter int unsigned OUTPUT_NB_CHANNELS = DEF_COUT,
  parameter int unsigned ADDR_WIDTH         = DEF_ADDR_WIDTH
) (
  input  logic                              clk,
  input  logic                              arst_n_in,
  input  logic                              start,
  output logic                              busy,
  output logic                              done,
  output logic                              act_mem_re,
  output logic [ADDR_WIDTH-1:0]             act_mem_addr,
  input  logic [KERNEL_SIZE*DATA_WIDTH-1:0] act_mem_rdata,
  output logic                              wgt_mem_re,
  output logic [ADDR_WIDTH-1:0]             wgt_mem_addr,
  input  logic [KERNEL_SIZE*DATA_WIDTH-1:0] wgt_mem_rdata,
  output logic                              a_valid,
  output logic                              b_valid,
  input  logic                              a_ready,
  input  logic                              b_ready,
  output logic [KERNEL_SIZE*DATA_WIDTH-1:0] a_data,
  output logic [KERNEL_SIZE*DATA_WIDTH-1:0] b_data
);

  localparam int unsigned WORD_W = KERNEL_SIZE * DATA_WIDTH;

  localparam logic [CNT_W-1:0] W_L    = CNT_W'(FEATURE_MAP_WIDTH);
  localparam logic [CNT_W-1:0] H_L    = CNT_W'(FEATURE_MAP_HEIGHT);
  localparam logic [CNT_W-1:0] CIN_L  = CNT_W'(INPUT_NB_CHANNELS);
  localparam logic [CNT_W-1:0] COUT_L = CNT_W'(OUTPUT_NB_CHANNELS);
  localparam logic [CNT_W-1:0] K_L    = CNT_W'(KERNEL_SIZE);

  localparam logic signed [CNT_W+1:0] ROW_MAX = (CNT_W+2)'(FEATURE_MAP_HEIGHT) - 34'sd1;

  feeder_state_t state, state_nxt;
  loop_idx_t     idx, idx_nxt;

  logic              issue;
  logic              last_idx;
  logic              row_pad;
  logic signed [CNT_W+1:0] row;
  logic              xfer;
  logic              rd_vld_q;   // a read pair is on the memory buses this cycle
  logic              rd_pad_q;   // that read belongs to a padded row
  logic [1:0]        fifo_cnt;
  logic [2:0]        outstanding;
  logic              fifo_vld;
  logic [2*WORD_W-1:0] fifo_push_data;
  logic [2*WORD_W-1:0] fifo_pop_data;

  assign xfer = fifo_vld && a_ready && b_ready;

  // Slots already committed once this cycle's transfer (if any) is credited.
  assign outstanding = 3'(fifo_cnt) + 3'(rd_vld_q) - 3'(xfer);

  // State register.
  always_ff @(posedge clk or negedge arst_n_in) begin
    if (!arst_n_in) state <= ST_IDLE;
    else            state <= state_nxt;
  end

  // Next-state: stream until the last pair is issued, then drain the buffer.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:   if (start) state_nxt = ST_STREAM;
      ST_STREAM: if (issue && last_idx) state_nxt = ST_DRAIN;
      ST_DRAIN:  if (!rd_vld_q && ((fifo_cnt == 2'd0) || ((fifo_cnt == 2'd1) && xfer)))
                   state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  // FSM outputs: issue gating and the end-of-pass pulse.
  always_comb begin
    busy  = (state != ST_IDLE);
    issue = (state == ST_STREAM) && (outstanding < 3'd2);
    done  = (state == ST_DRAIN) && !rd_vld_q && (fifo_cnt == 2'd1) && xfer;
  end

  // Loop-nest successor; k_v is innermost, x outermost.
  always_comb begin
    idx_nxt     = idx;
    idx_nxt.k_v = wrap_inc(idx.k_v, K_L);
    if (is_last(idx.k_v, K_L)) begin
      idx_nxt.ch_out = wrap_inc(idx.ch_out, COUT_L);
      if (is_last(idx.ch_out, COUT_L)) begin
        idx_nxt.ch_in = wrap_inc(idx.ch_in, CIN_L);
        if (is_last(idx.ch_in, CIN_L)) begin
          idx_nxt.y = wrap_inc(idx.y, H_L);
          if (is_last(idx.y, H_L)) idx_nxt.x = wrap_inc(idx.x, W_L);
        end
      end
    end
    last_idx = is_last(idx.k_v, K_L) && is_last(idx.ch_out, COUT_L) &&
               is_last(idx.ch_in, CIN_L) && is_last(idx.y, H_L) && is_last(idx.x, W_L);
  end

  // Loop counters move only when a read pair is issued.
  always_ff @(posedge clk or negedge arst_n_in) begin
    if (!arst_n_in)                      idx <= '0;
    else if ((state == ST_IDLE) && start) idx <= '0;
    else if (issue)                      idx <= idx_nxt;
  end

  // Activation row for the current tap; outside the map it is zero padding.
  always_comb begin
    row     = $signed({2'b00, idx.y}) + $signed({2'b00, idx.k_v}) - 34'sd1;
    row_pad = (row < 34'sd0) || (row > ROW_MAX);
  end

  // Read requests; addresses idle at 0 when no read is made.
  always_comb begin
    act_mem_re   = issue && !row_pad;
    wgt_mem_re   = issue;
    act_mem_addr = act_mem_re
                 ? ADDR_WIDTH'((row[CNT_W-1:0] * W_L + idx.x) * CIN_L + idx.ch_in)
                 : '0;
    wgt_mem_addr = wgt_mem_re
                 ? ADDR_WIDTH'((idx.ch_out * CIN_L + idx.ch_in) * K_L + idx.k_v)
                 : '0;
  end

  // Track the one-cycle memory latency; reset drops any read in flight.
  always_ff @(posedge clk or negedge arst_n_in) begin
    if (!arst_n_in) begin
      rd_vld_q <= 1'b0;
      rd_pad_q <= 1'b0;
    end else begin
      rd_vld_q <= issue;
      rd_pad_q <= issue && row_pad;
    end
  end

  // Padded rows replace the (unread) activation bus with zeros.
  always_comb begin
    fifo_push_data = {wgt_mem_rdata, rd_pad_q ? {WORD_W{1'b0}} : act_mem_rdata};
  end

  skid_fifo2 #(.WIDTH(2*WORD_W)) u_fifo (
    .clk        (clk),
    .arst_n_in  (arst_n_in),
    .push_valid (rd_vld_q),
    .push_data  (fifo_push_data),
    .pop_valid  (fifo_vld),
    .pop_data   (fifo_pop_data),
    .pop_ready  (a_ready && b_ready),
    .count      (fifo_cnt)
  );

  assign a_valid = fifo_vld;
  assign b_valid = fifo_vld;
  assign a_data  = fifo_pop_data[WORD_W-1:0];
  assign b_data  = fifo_pop_data[2*WORD_W-1:WORD_W];

endmodule

// File: tb/tb_ab_stream_feeder.sv
// Directed bench for ab_stream_feeder on a 4x4x2x2 layer with K=3.
module tb_ab_stream_feeder;

  localparam int W = 4, H = 4, CIN = 2, COUT = 2, K = 3, DW = 16, AW = 20;
  localparam int WW = K * DW;
  localparam int NP = W * H * CIN * COUT * K;   // 192
  localparam logic [WW-1:0] GARB = 48'hDEAD_BEEF_CAFE;

  logic clk = 1'b0;
  logic arst_n_in = 1'b0, start = 1'b0, a_ready = 1'b0, b_ready = 1'b0;
  logic busy, done, act_mem_re, wgt_mem_re, a_valid, b_valid;
  logic [AW-1:0] act_mem_addr, wgt_mem_addr;
  logic [WW-1:0] act_mem_rdata, wgt_mem_rdata, a_data, b_data;

  always #5 clk = ~clk;

  ab_stream_feeder #(
    .DATA_WIDTH(DW), .KERNEL_SIZE(K), .FEATURE_MAP_WIDTH(W), .FEATURE_MAP_HEIGHT(H),
    .INPUT_NB_CHANNELS(CIN), .OUTPUT_NB_CHANNELS(COUT), .ADDR_WIDTH(AW)
  ) dut (
    .clk(clk), .arst_n_in(arst_n_in), .start(start), .busy(busy), .done(done),
    .act_mem_re(act_mem_re), .act_mem_addr(act_mem_addr), .act_mem_rdata(act_mem_rdata),
    .wgt_mem_re(wgt_mem_re), .wgt_mem_addr(wgt_mem_addr), .wgt_mem_rdata(wgt_mem_rdata),
    .a_valid(a_valid), .b_valid(b_valid), .a_ready(a_ready), .b_ready(b_ready),
    .a_data(a_data), .b_data(b_data)
  );

  int n_cmp = 0, n_err = 0;

  function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction

  // Memory contents: every lane carries a distinct nonzero value.
  function automatic logic [WW-1:0] act_word(int addr);
    logic [WW-1:0] w;
    for (int l = 0; l < K; l++) w[l*DW +: DW] = 16'(addr * K + l + 1);
    return w;
  endfunction

  function automatic logic [WW-1:0] wgt_word(int addr);
    logic [WW-1:0] w;
    for (int l = 0; l < K; l++) w[l*DW +: DW] = 16'h8000 | 16'(addr * K + l);
    return w;
  endfunction

  // One-cycle synchronous memories; unread cycles return garbage.
  always @(posedge clk) begin
    act_mem_rdata <= act_mem_re ? act_word(int'(act_mem_addr)) : GARB;
    wgt_mem_rdata <= wgt_mem_re ? wgt_word(int'(wgt_mem_addr)) : GARB;
  end

  // Golden loop nest.
  logic [WW-1:0] exp_a [NP];
  logic [WW-1:0] exp_b [NP];
  logic          exp_are [NP];
  int            exp_aaddr [NP];
  int            exp_waddr [NP];

  initial begin : build_model
    int n;
    n = 0;
    for (int x = 0; x < W; x++)
      for (int y = 0; y < H; y++)
        for (int ci = 0; ci < CIN; ci++)
          for (int co = 0; co < COUT; co++)
            for (int kv = 0; kv < K; kv++) begin
              int row;
              logic pad;
              row = y + kv - 1;
              pad = (row < 0) || (row >= H);
              exp_are[n]   = !pad;
              exp_aaddr[n] = pad ? 0 : (row * W + x) * CIN + ci;
              exp_waddr[n] = (co * CIN + ci) * K + kv;
              exp_a[n]     = pad ? '0 : act_word(exp_aaddr[n]);
              exp_b[n]     = wgt_word(exp_waddr[n]);
              n++;
            end
  end

  // Compare process: issue order, transfers, hold stability, occupancy, done.
  int acc_idx = 0, iss_idx = 0, run_done = 0;
  logic hold_q = 1'b0;
  logic [WW-1:0] hold_a, hold_b;

  initial begin : monitor
    forever begin
      logic xfer;
      @(negedge clk);
      if (!arst_n_in) begin
        acc_idx = 0; iss_idx = 0; hold_q = 1'b0;
      end else begin
        if (!busy && start) begin acc_idx = 0; iss_idx = 0; run_done = 0; end
        if (act_mem_re || wgt_mem_re) begin
          if (iss_idx < NP) begin
            chk("wgt_re", 64'(wgt_mem_re), 64'd1);
            chk("wgt_addr", 64'(wgt_mem_addr), 64'(exp_waddr[iss_idx]));
            chk("act_re", 64'(act_mem_re), 64'(exp_are[iss_idx]));
            chk("act_addr", 64'(act_mem_addr), 64'(exp_aaddr[iss_idx]));
          end else begin
            n_cmp++; n_err++;
            $display("FAIL issue_overrun: issue #%0d beyond %0d", iss_idx, NP);
          end
          iss_idx++;
        end
        chk("b_valid_eq", 64'(b_valid), 64'(a_valid));
        if (hold_q) begin
          chk("hold_valid", 64'(a_valid), 64'd1);
          chk("hold_a", 64'(a_data), 64'(hold_a));
          chk("hold_b", 64'(b_data), 64'(hold_b));
        end
        xfer = a_valid && a_ready && b_ready;
        if (xfer) begin
          if (acc_idx < NP) begin
            chk("a_data", 64'(a_data), 64'(exp_a[acc_idx]));
            chk("b_data", 64'(b_data), 64'(exp_b[acc_idx]));
          end else begin
            n_cmp++; n_err++;
            $display("FAIL xfer_overrun: pair #%0d beyond %0d", acc_idx, NP);
          end
          acc_idx++;
        end
        chk("outstanding_le2", 64'((iss_idx - acc_idx) <= 2), 64'd1);
        hold_q = a_valid && !xfer;
        hold_a = a_data;
        hold_b = b_data;
        if (done) begin
          run_done++;
          chk("done_at_last", 64'(acc_idx), 64'(NP));
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_busy"},     64'(busy), 64'd0);
    chk({tag, "_done"},     64'(done), 64'd0);
    chk({tag, "_act_re"},   64'(act_mem_re), 64'd0);
    chk({tag, "_act_addr"}, 64'(act_mem_addr), 64'd0);
    chk({tag, "_wgt_re"},   64'(wgt_mem_re), 64'd0);
    chk({tag, "_wgt_addr"}, 64'(wgt_mem_addr), 64'd0);
    chk({tag, "_a_valid"},  64'(a_valid), 64'd0);
    chk({tag, "_b_valid"},  64'(b_valid), 64'd0);
    chk({tag, "_a_data"},   64'(a_data), 64'd0);
    chk({tag, "_b_data"},   64'(b_data), 64'd0);
  endtask

  task automatic wait_done(input string tag, input int budget, output int cycles);
    int d0;
    d0 = run_done;
    cycles = 0;
    while (run_done == d0 && cycles < budget) begin tick(1); cycles++; end
    if (run_done == d0) begin
      n_cmp++; n_err++;
      $display("FAIL %s_timeout: no done within %0d cycles", tag, budget);
    end
  endtask

  task automatic check_pass(input string tag);
    tick(3);
    chk({tag, "_pairs"},     64'(acc_idx), 64'(NP));
    chk({tag, "_issues"},    64'(iss_idx), 64'(NP));
    chk({tag, "_done_once"}, 64'(run_done), 64'd1);
    chk({tag, "_idle"},      64'(busy), 64'd0);
  endtask

  initial begin : stim
    int cyc, acc0;
    tick(2);
    check_reset_outputs("por");

    // Pin the golden model with hand-computed entries.
    chk("model_a0", 64'(exp_a[0]), 64'h0);
    chk("model_b0", 64'(exp_b[0]), 64'h8002_8001_8000);
    chk("model_a1", 64'(exp_a[1]), 64'h0003_0002_0001);
    chk("model_a7", 64'(exp_a[7]), 64'h0006_0005_0004);
    chk("model_a191", 64'(exp_a[NP-1]), 64'h0);
    chk("model_b191", 64'(exp_b[NP-1]), 64'h8023_8022_8021);

    arst_n_in = 1'b1;
    tick(2);

    // Pass 1: ready held high, plus a stray start mid-stream.
    a_ready = 1'b1; b_ready = 1'b1; start = 1'b1;
    tick(1);
    start = 1'b0;
    chk("busy_after_start", 64'(busy), 64'd1);
    chk("valid_lat0", 64'(a_valid), 64'd0);
    tick(1);
    chk("valid_lat1", 64'(a_valid), 64'd0);
    tick(1);
    chk("valid_lat2", 64'(a_valid), 64'd1);
    chk("first_a_pad", 64'(a_data), 64'h0);
    chk("first_b", 64'(b_data), 64'h8002_8001_8000);
    tick(40);
    start = 1'b1;
    tick(1);
    start = 1'b0;
    wait_done("run1", 1000, cyc);
    chk("run1_latency", 64'(2 + 40 + 1 + cyc), 64'd194);
    check_pass("run1");

    // Pass 2: ready pattern 1,0,0,1 repeating.
    start = 1'b1;
    tick(1);
    start = 1'b0;
    cyc = 0;
    while (run_done == 0 && cyc < 2000) begin
      a_ready = ((cyc % 4) == 0) || ((cyc % 4) == 3);
      b_ready = a_ready;
      tick(1);
      cyc++;
    end
    if (run_done == 0) begin
      n_cmp++; n_err++;
      $display("FAIL run2_timeout: no done within 2000 cycles");
    end
    a_ready = 1'b1; b_ready = 1'b1;
    check_pass("run2");

    // Pass 3: b_ready low alone for 5 cycles stalls everything.
    start = 1'b1;
    tick(1);
    start = 1'b0;
    tick(20);
    acc0 = acc_idx;
    b_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("stall_act_re", 64'(act_mem_re), 64'd0);
      chk("stall_wgt_re", 64'(wgt_mem_re), 64'd0);
      chk("stall_valid", 64'(a_valid), 64'd1);
      tick(1);
    end
    chk("stall_no_xfer", 64'(acc_idx), 64'(acc0));
    b_ready = 1'b1;
    wait_done("run3", 1000, cyc);
    check_pass("run3");

    // Pass 4: reset at pair 50, then a clean restart.
    start = 1'b1;
    tick(1);
    start = 1'b0;
    cyc = 0;
    while (acc_idx < 50 && cyc < 500) begin tick(1); cyc++; end
    chk("reach_pair50", 64'(acc_idx >= 50), 64'd1);
    arst_n_in = 1'b0;
    #1;
    check_reset_outputs("midpass");
    tick(2);
    arst_n_in = 1'b1;
    tick(2);
    check_reset_outputs("post_rst");
    start = 1'b1;
    tick(1);
    start = 1'b0;
    wait_done("run4", 1000, cyc);
    check_pass("run4");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
